// File: rtl/serial_sub_pkg.sv
// serial_sub_defs: state encodings shared by the bit-serial subtractor.
package serial_sub_defs;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/serial_sub_full_sub.sv
// full_sub: one-bit full subtractor, d = x - y - bi with borrow-out bo.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done handshake.
module serial_sub
   import serial_sub_defs::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
   logic             d, bo;

   full_sub u_fs (.x(sa_q[0]), .y(sb_q[0]), .bi(br_q), .d(d), .bo(bo));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sd_d    = sd_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         ST_RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sd_d  = {d, sd_q[WIDTH-1:1]};
            br_d  = bo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d  = sd_d;
               bout_d  = bo;
               state_d = ST_DONE;
            end
         end
         // IDLE, DONE and the unreachable encoding all accept a new request
         default: begin
            state_d = start ? ST_RUN : ST_IDLE;
            if (start) begin
               sa_d  = a;
               sb_d  = b;
               br_d  = bin;
               cnt_d = '0;
               sd_d  = '0;
            end
         end
      endcase
      busy_d = state_d == ST_RUN;
      done_d = state_d == ST_DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sd_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sd_q    <= sd_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: random and directed checks of serial_sub (WIDTH 8 and 13) against a behavioural model.
module tb_serial_sub;
   logic     clk = 1'b0;
   int       checks = 0;
   int       passes = 0;
   bit [1:0] fin = 2'b00;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   logic fx, fy, fbi, fd, fbo;
   full_sub u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

   for (genvar g = 0; g < 2; g++) begin : gen_w
      localparam int W = (g == 0) ? 8 : 13;
      logic         rst = 1'b1, start = 1'b0, bin = 1'b0;
      logic [W-1:0] a = '0, b = '0;
      logic         busy, done, bout;
      logic [W-1:0] diff;

      serial_sub #(.WIDTH(W)) dut (
         .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
         .busy(busy), .done(done), .diff(diff), .bout(bout)
      );

      // Model: an accepted request completes W edges later with {borrow,diff} = a - b - bin.
      int     rem = 0;
      logic [W:0] pend = '0, res = '0;
      logic   m_busy = 1'b0, m_done = 1'b0;
      bit     armed = 1'b0;

      always @(posedge clk) begin
         if (rst) begin
            rem = 0; res = '0; m_done = 1'b0; armed = 1'b1;
         end else if (rem > 0) begin
            rem--;
            m_done = (rem == 0);
            if (rem == 0) res = pend;
         end else begin
            m_done = 1'b0;
            if (start) begin
               pend = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
               rem  = W;
            end
         end
         m_busy = rem > 0;
      end

      always @(negedge clk) begin
         if (armed) begin
            chk($sformatf("w%0d busy", W), 32'(busy), 32'(m_busy));
            chk($sformatf("w%0d done", W), 32'(done), 32'(m_done));
            chk($sformatf("w%0d diff", W), 32'(diff), 32'(res[W-1:0]));
            chk($sformatf("w%0d bout", W), 32'(bout), 32'(res[W]));
         end
      end

      task automatic cyc(input int n);
         repeat (n) @(posedge clk);
         #1;
      endtask

      task automatic wait_done(output int k, output int nb);
         k = 0; nb = 0;
         while (done !== 1'b1 && k < W + 5) begin
            nb += int'(busy);
            cyc(1);
            k++;
         end
      endtask

      // One operation; operands are scrambled right after acceptance.
      task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                        output int k, output int nb);
         start = 1'b1; a = aa; b = bb; bin = bi;
         cyc(1);
         start = 1'($urandom); a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         wait_done(k, nb);
         chk($sformatf("w%0d latency", W), 32'(k), 32'(W));
         start = 1'b0;
      endtask

      task automatic rand_run(input int n);
         int k, nb;
         for (int i = 0; i < n; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), k, nb);
            if ($urandom_range(0, 2) != 0) cyc($urandom_range(1, 3));
         end
         cyc(3);
      endtask

      if (W == 8) begin : g_dir
         initial begin
            int k, nb, nd;
            cyc(2);
            rst = 1'b0;
            chk("reset busy", 32'(busy), 0);
            chk("reset done", 32'(done), 0);
            chk("reset diff", 32'(diff), 0);
            chk("reset bout", 32'(bout), 0);
            op(8'h5A, 8'h23, 1'b0, k, nb);
            chk("5A-23 diff", 32'(diff), 32'h37);
            chk("5A-23 bout", 32'(bout), 0);
            chk("5A-23 busy cycles", 32'(nb), 8);
            cyc(2);
            op(8'h10, 8'h20, 1'b0, k, nb);
            chk("10-20 diff", 32'(diff), 32'hF0);
            chk("10-20 bout", 32'(bout), 1);
            op(8'h00, 8'h00, 1'b1, k, nb);
            chk("00-00-1 diff", 32'(diff), 32'hFF);
            chk("00-00-1 bout", 32'(bout), 1);
            op(8'hFF, 8'hFF, 1'b0, k, nb);
            chk("FF-FF diff", 32'(diff), 32'h00);
            chk("FF-FF bout", 32'(bout), 0);
            cyc(2);
            start = 1'b1; a = 8'h80; b = 8'h01; bin = 1'b0;
            cyc(1);
            a = 8'hC4; b = 8'h3B; bin = 1'b1;
            wait_done(k, nb);
            chk("b2b first period", 32'(k), 8);
            chk("b2b first diff", 32'(diff), 32'h7F);
            chk("b2b first bout", 32'(bout), 0);
            a = 8'h03; b = 8'h05; bin = 1'b0;
            cyc(1);
            a = 8'h9E; b = 8'h12; bin = 1'b1;
            wait_done(k, nb);
            chk("b2b second period", 32'(k), 8);
            chk("b2b second diff", 32'(diff), 32'hFE);
            chk("b2b second bout", 32'(bout), 1);
            start = 1'b0;
            cyc(3);
            start = 1'b1; a = 8'hAA; b = 8'h55;
            cyc(1);
            start = 1'b0;
            cyc(3);
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
            chk("midrun rst busy", 32'(busy), 0);
            chk("midrun rst done", 32'(done), 0);
            chk("midrun rst diff", 32'(diff), 0);
            chk("midrun rst bout", 32'(bout), 0);
            nd = 0;
            for (int i = 0; i < W + 3; i++) begin nd += int'(done); cyc(1); end
            chk("midrun rst no done", 32'(nd), 0);
            rand_run(3000);
            fin[g] = 1'b1;
         end
      end else begin : g_rnd
         initial begin
            cyc(2);
            rst = 1'b0;
            rand_run(3000);
            fin[g] = 1'b1;
         end
      end
   end

   initial begin
      int t = 0;
      for (int i = 0; i < 8; i++) begin
         int r;
         {fx, fy, fbi} = 3'(i);
         #1;
         r = int'(fx) - int'(fy) - int'(fbi);
         chk($sformatf("full_sub d %0d", i), 32'(fd), 32'(r & 1));
         chk($sformatf("full_sub bo %0d", i), 32'(fbo), 32'(r < 0));
      end
      while (fin != 2'b11 && t < 90000) begin @(posedge clk); t++; end
      if (fin != 2'b11) begin
         checks++;
         $display("FAIL timeout: got fin=%b expected 11", fin);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
